// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding and default width.
// Package bsa_pkg is imported by fa_mux_cell and bit_serial_adder_ctrl.
package bsa_pkg;

    localparam int BSA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } bsa_state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_fa.sv
// One-bit full adder realised as two 8:1 mux lookups indexed by {a, b, carry-in}.
module fa_mux_cell
    import bsa_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    // Truth tables: bit n holds the result for select value n = {a, b, c}
    localparam logic [7:0] SUM_LUT   = 8'b1001_0110;
    localparam logic [7:0] CARRY_LUT = 8'b1110_1000;

    logic [2:0] w_sel;

    assign w_sel   = {i_a, i_b, i_c};
    assign o_sum   = SUM_LUT[w_sel];
    assign o_carry = CARRY_LUT[w_sel];

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through one fa_mux_cell.
// Optional subtract mode (port sub) is enabled by defining BSA_SUB_EN.
module bit_serial_adder_ctrl
    import bsa_pkg::*;
#(
    parameter  int WIDTH = BSA_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef BSA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    bsa_state_t       r_state;
    bsa_state_t       w_nextState;
    logic [WIDTH-1:0] r_aSh;
    logic [WIDTH-1:0] r_bSh;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic [WIDTH-1:0] w_bLoad;
    logic             w_cLoad;
    logic             w_accept;
    logic             w_lastBit;
    logic             w_faSum;
    logic             w_faCarry;

    // Subtraction is a + ~b + 1, so only the captured B and carry differ
`ifdef BSA_SUB_EN
    assign w_bLoad = sub ? ~b : b;
    assign w_cLoad = sub ? 1'b1 : cin;
`else
    assign w_bLoad = b;
    assign w_cLoad = cin;
`endif

    assign w_accept  = (r_state == IDLE) && start;
    assign w_lastBit = (r_cnt == CNT_W'(WIDTH - 1));
    assign sum       = r_sum;
    assign cout      = r_cout;

    fa_mux_cell u_fa (
        .i_a     (r_aSh[0]),
        .i_b     (r_bSh[0]),
        .i_c     (r_carry),
        .o_sum   (w_faSum),
        .o_carry (w_faCarry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aSh   <= '0;
            r_bSh   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_aSh   <= a;
            r_bSh   <= w_bLoad;
            r_carry <= w_cLoad;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_aSh   <= r_aSh >> 1;
            r_bSh   <= r_bSh >> 1;
            r_sum   <= WIDTH'({w_faSum, r_sum} >> 1);
            r_carry <= w_faCarry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_lastBit) begin
                r_cout <= w_faCarry;
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Self-checking bench for bit_serial_adder_ctrl: vector table, corner sequences, random ops.
// Subtract vectors are included when BSA_SUB_EN is defined.
module tb_bit_serial_adder_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;
    localparam int BOUND = 4 * WIDTH + 10;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct {
        word_t a;
        word_t b;
        logic  cin;
        logic  sub;
        word_t expSum;
        logic  expCout;
    } vec_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  start = 1'b0;
    logic  cin   = 1'b0;
    logic  sub   = 1'b0;
    word_t a     = '0;
    word_t b     = '0;
    logic  busy;
    logic  done;
    logic  cout;
    word_t sum;

    int checks = 0;
    int errors = 0;

    vec_t        vecs[$];
    logic [WIDTH:0] expQ[$];

    bit_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef BSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic, {carry/no-borrow, result}
    function automatic logic [WIDTH:0] refModel(input word_t x, input word_t y, input logic c, input logic s);
        longint unsigned t;
        word_t           d;
        if (s) begin
            d = x - y;
            return {(x >= y), d};
        end
        t = longint'(x) + longint'(y) + longint'(c);
        return t[WIDTH:0];
    endfunction

    // One complete operation; operands are scrambled right after acceptance
    task automatic applyStimulus(input word_t x, input word_t y, input logic c, input logic s,
                                 output word_t gotSum, output logic gotCout);
        int   lat;
        logic busyOk;
        @(negedge clk);
        a = x; b = y; cin = c; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = word_t'($urandom); b = word_t'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        busyOk = 1'b1;
        for (int n = 1; n <= BOUND; n++) begin
            @(negedge clk);
            if (!busy) busyOk = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        gotSum  = sum;
        gotCout = cout;
        checkOutput("latency", 64'(lat), 64'(LAT));
        checkOutput("busyDuringOp", 64'(busyOk), 64'd1);
        @(negedge clk);
        checkOutput("idleAfterDone", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        word_t gotSum;
        logic  gotCout;
        word_t x, y;
        logic  c, s;
        int    prevDone;
        logic  doneSeen;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetBusyDone", {62'd0, busy, done}, 64'd0);
        checkOutput("resetSum", 64'(sum), 64'd0);
        checkOutput("resetCout", 64'(cout), 64'd0);
        rst_n = 1'b1;

        vecs.push_back('{8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0});
`ifdef BSA_SUB_EN
        vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0});
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, gotSum, gotCout);
            checkOutput($sformatf("vec%0d.sum", i), 64'(gotSum), 64'(vecs[i].expSum));
            checkOutput($sformatf("vec%0d.cout", i), 64'(gotCout), 64'(vecs[i].expCout));
        end

        // Result must survive idle cycles with start low and operands wiggling
        repeat (3) begin
            @(negedge clk);
            a = word_t'($urandom); b = word_t'($urandom);
        end
        checkOutput("holdSum", {55'd0, cout, sum}, {55'd0, vecs[vecs.size()-1].expCout, vecs[vecs.size()-1].expSum});

        // start held high: back-to-back ops, operands scrambled while busy
        prevDone = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("b2bSpuriousDone", 64'd1, 64'd0);
                end else begin
                    checkOutput("b2bResult", 64'({cout, sum}), 64'(expQ.pop_front()));
                end
                if (prevDone >= 0) checkOutput("b2bInterval", 64'(cyc - prevDone), 64'd10);
                prevDone = cyc;
            end
            if (cyc < 40) begin
                start = 1'b1;
                if (!busy) begin
                    x = word_t'($urandom); y = word_t'($urandom); c = 1'($urandom);
`ifdef BSA_SUB_EN
                    s = 1'($urandom);
`else
                    s = 1'b0;
`endif
                    a = x; b = y; cin = c; sub = s;
                    expQ.push_back(refModel(x, y, c, s));
                end else begin
                    a = word_t'($urandom); b = word_t'($urandom);
                    cin = 1'($urandom); sub = 1'($urandom);
                end
            end else begin
                start = 1'b0;
            end
        end
        checkOutput("b2bDrained", 64'(expQ.size()), 64'd0);
        checkOutput("b2bSawOps", 64'(prevDone >= 0), 64'd1);

        // Abort in the middle of RUN
        @(negedge clk);
        a = 8'hC3; b = 8'h5A; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortState", {53'd0, busy, done, cout, sum}, 64'd0);
        doneSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            doneSeen = doneSeen | done;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            doneSeen = doneSeen | done;
        end
        checkOutput("abortNoDone", 64'(doneSeen), 64'd0);
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, gotSum, gotCout);
        checkOutput("postAbortSum", 64'(gotSum), 64'h03);
        checkOutput("postAbortCout", 64'(gotCout), 64'd0);

        // Random ops against the arithmetic reference
        for (int k = 0; k < 20; k++) begin
            x = word_t'($urandom); y = word_t'($urandom); c = 1'($urandom);
`ifdef BSA_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            applyStimulus(x, y, c, s, gotSum, gotCout);
            checkOutput($sformatf("rand%0d", k), 64'({gotCout, gotSum}), 64'(refModel(x, y, c, s)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
